// File: rtl/screen_sel_ctl_if.sv
// screen_sel_ctl_if: renderer video buses in, selected registered video out
interface screen_sel_ctl_if #(parameter int NUM_SCREENS = 4);
  logic [NUM_SCREENS-1:0]    vsync_bus;
  logic [NUM_SCREENS-1:0]    hsync_bus;
  logic [12*NUM_SCREENS-1:0] rgb_bus;
  logic                      vsync_out;
  logic                      hsync_out;
  logic [11:0]               rgb_out;
  modport slave (input vsync_bus, hsync_bus, rgb_bus, output vsync_out, hsync_out, rgb_out);
  modport master (output vsync_bus, hsync_bus, rgb_bus, input vsync_out, hsync_out, rgb_out);
endinterface

// File: rtl/screen_sel_ctl.sv
// screen_sel_ctl: menu hit-testing, back-button debounce and frame-aligned screen/video select
module screen_sel_ctl #(
  parameter int NUM_SCREENS     = 4,
  parameter int NUM_BTNS        = 4,
  parameter int DIFF_LEVELS     = 4,
  parameter int BTN_X0          = 362,
  parameter int BTN_X1          = 674,
  parameter int BTN_Y0          = 46,
  parameter int BTN_H           = 100,
  parameter int BTN_PITCH       = 192,
  parameter int DEBOUNCE_CYCLES = 65000,
  localparam int SW = $clog2(NUM_SCREENS),
  localparam int DW = $clog2(DIFF_LEVELS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vblnk_in,
  input  logic [11:0]          xpos,
  input  logic [11:0]          ypos,
  input  logic                 mouse_left,
  input  logic                 button,
  screen_sel_ctl_if.slave      vid,
  output logic [SW-1:0]        screen,
  output logic [DW-1:0]        difficulty,
  output logic                 switch_pending
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic          mouse_q, vblnk_q, sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] screen_q, screen_d, tgt_q, tgt_d;
  logic [DW-1:0] diff_q, diff_d;
  logic          pend_q, pend_d;
  logic          click, frame_edge, back_pulse;
  logic [NUM_BTNS-1:0] hit;
  logic          req_v, diff_inc;
  logic [SW-1:0] req_t;
  logic [31:0]   xw, yw;

  assign click      = mouse_left & ~mouse_q;
  assign frame_edge = vblnk_in & ~vblnk_q;
  assign xw         = 32'(xpos);
  assign yw         = 32'(ypos);
  assign back_pulse = sync2_q && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
  assign cnt_d      = !sync2_q ? '0 : (cnt_q == CW'(DEBOUNCE_CYCLES) ? cnt_q : cnt_q + 1'b1);

  always_comb begin
    hit = '0;
    for (int j = 0; j < NUM_BTNS; j++)
      hit[j] = xw >= 32'(BTN_X0) && xw <= 32'(BTN_X1) &&
               yw >= 32'(BTN_Y0 + j*BTN_PITCH) && yw <= 32'(BTN_Y0 + j*BTN_PITCH + BTN_H);
  end

  // Requests are judged against the committed screen; button 1 is the difficulty toggle.
  always_comb begin
    req_v    = 1'b0;
    req_t    = '0;
    diff_inc = 1'b0;
    if (screen_q == '0) begin
      if (click)
        for (int j = NUM_BTNS - 1; j >= 0; j--)
          if (hit[j]) begin
            req_v    = (j != 1);
            req_t    = (j == 0) ? SW'(1) : SW'(j);
            diff_inc = (j == 1);
          end
    end else if (back_pulse) begin
      req_v = 1'b1;
      req_t = '0;
    end
  end

  always_comb begin
    diff_d   = diff_inc ? (diff_q == DW'(DIFF_LEVELS - 1) ? '0 : diff_q + 1'b1) : diff_q;
    tgt_d    = req_v ? req_t : tgt_q;
    pend_d   = frame_edge ? 1'b0 : (req_v | pend_q);
    screen_d = !frame_edge ? screen_q : (req_v ? req_t : (pend_q ? tgt_q : screen_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mouse_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      cnt_q         <= '0;
      screen_q      <= '0;
      tgt_q         <= '0;
      diff_q        <= '0;
      pend_q        <= 1'b0;
      vid.vsync_out <= 1'b0;
      vid.hsync_out <= 1'b0;
      vid.rgb_out   <= '0;
    end else begin
      mouse_q       <= mouse_left;
      vblnk_q       <= vblnk_in;
      sync1_q       <= button;
      sync2_q       <= sync1_q;
      cnt_q         <= cnt_d;
      screen_q      <= screen_d;
      tgt_q         <= tgt_d;
      diff_q        <= diff_d;
      pend_q        <= pend_d;
      vid.vsync_out <= vid.vsync_bus[screen_q];
      vid.hsync_out <= vid.hsync_bus[screen_q];
      vid.rgb_out   <= vid.rgb_bus[int'(screen_q)*12 +: 12];
    end
  end

  assign screen         = screen_q;
  assign difficulty     = diff_q;
  assign switch_pending = pend_q;
endmodule

// File: tb/tb_screen_sel_ctl.sv
// tb_screen_sel_ctl: directed checks of hit-testing, debounce, difficulty and frame-aligned switching
module tb_screen_sel_ctl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vblnk_in = 1'b0;
  logic [11:0] xpos = '0;
  logic [11:0] ypos = '0;
  logic        mouse_left = 1'b0;
  logic        button = 1'b0;
  logic [1:0]  screen;
  logic [1:0]  difficulty;
  logic        switch_pending;
  int          total = 0;
  int          bad = 0;

  screen_sel_ctl_if #(.NUM_SCREENS(4)) vid();

  screen_sel_ctl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .vblnk_in(vblnk_in), .xpos(xpos), .ypos(ypos),
    .mouse_left(mouse_left), .button(button), .vid(vid), .screen(screen),
    .difficulty(difficulty), .switch_pending(switch_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic click(input int x, input int y);
    xpos = 12'(x);
    ypos = 12'(y);
    mouse_left = 1'b1;
    tick(1);
    mouse_left = 1'b0;
    tick(1);
  endtask

  task automatic frame();
    vblnk_in = 1'b1;
    tick(1);
    vblnk_in = 1'b0;
    tick(1);
  endtask

  task automatic back_hold(input int n);
    button = 1'b1;
    tick(n);
    button = 1'b0;
    tick(4);
  endtask

  initial begin
    vid.vsync_bus = 4'b0010;
    vid.hsync_bus = 4'b0101;
    vid.rgb_bus   = {12'h789, 12'h456, 12'h123, 12'hABC};
    #3;
    chk("rst_screen", screen, 0);
    chk("rst_diff", difficulty, 0);
    chk("rst_pend", switch_pending, 0);
    chk("rst_vsync", vid.vsync_out, 0);
    chk("rst_hsync", vid.hsync_out, 0);
    chk("rst_rgb", vid.rgb_out, 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("menu_rgb", vid.rgb_out, 12'hABC);
    chk("menu_vsync", vid.vsync_out, 0);
    chk("menu_hsync", vid.hsync_out, 1);
    click(361, 46);
    chk("miss_x", switch_pending, 0);
    click(362, 147);
    chk("miss_y", switch_pending, 0);
    for (int i = 0; i < 5; i++) begin
      click(500, 300);
      chk("diff_step", difficulty, (i + 1) % 4);
      chk("diff_nopend", switch_pending, 0);
    end
    mouse_left = 1'b1;
    tick(1000);
    mouse_left = 1'b0;
    tick(1);
    chk("diff_hold", difficulty, 2);
    click(362, 46);
    chk("btn0_pend", switch_pending, 1);
    tick(5);
    chk("btn0_wait", screen, 0);
    vblnk_in = 1'b1;
    tick(1);
    chk("btn0_commit", screen, 1);
    chk("btn0_pend_clr", switch_pending, 0);
    chk("btn0_rgb_lat", vid.rgb_out, 12'hABC);
    vblnk_in = 1'b0;
    tick(1);
    chk("game_rgb", vid.rgb_out, 12'h123);
    chk("game_vsync", vid.vsync_out, 1);
    chk("game_hsync", vid.hsync_out, 0);
    click(362, 46);
    chk("game_click_ign", switch_pending, 0);
    back_hold(3);
    tick(4);
    chk("glitch", switch_pending, 0);
    button = 1'b1;
    tick(10);
    chk("back_pend", switch_pending, 1);
    chk("back_wait", screen, 1);
    frame();
    chk("back_commit", screen, 0);
    chk("back_rgb", vid.rgb_out, 12'hABC);
    click(362, 46);
    frame();
    chk("regame", screen, 1);
    tick(50);
    chk("back_once", switch_pending, 0);
    button = 1'b0;
    tick(5);
    back_hold(10);
    frame();
    chk("to_menu", screen, 0);
    back_hold(10);
    chk("menu_back_ign", switch_pending, 0);
    frame();
    chk("menu_back_scr", screen, 0);
    click(400, 622);
    click(400, 430);
    frame();
    chk("latest_wins", screen, 2);
    chk("scr2_rgb", vid.rgb_out, 12'h456);
    back_hold(10);
    frame();
    chk("scr2_back", screen, 0);
    xpos = 12'd400;
    ypos = 12'd622;
    mouse_left = 1'b1;
    vblnk_in = 1'b1;
    tick(1);
    chk("same_cycle", screen, 3);
    chk("same_cycle_pend", switch_pending, 0);
    mouse_left = 1'b0;
    vblnk_in = 1'b0;
    tick(2);
    back_hold(10);
    frame();
    click(400, 430);
    chk("pre_rst_pend", switch_pending, 1);
    chk("pre_rst_diff", difficulty, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_scr", screen, 0);
    chk("mid_rst_diff", difficulty, 0);
    chk("mid_rst_pend", switch_pending, 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    frame();
    chk("post_rst_scr", screen, 0);
    chk("post_rst_pend", switch_pending, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
